// File: rtl/vdp_ctrl_port.sv
// VDP control-port engine: two-byte command decoder, NUM_REGS control registers,
// auto-incrementing VRAM pointer with read-ahead, req/ack VRAM handshake, status/irq.
module vdp_ctrl_port #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr0_tick,
  input  logic                  rd0_tick,
  input  logic                  wr1_tick,
  input  logic                  rd1_tick,
  input  logic [7:0]            din,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic [7:0]            rdata,
  output logic [7:0]            status,
  output logic                  irq,
  input  logic                  frame_tick,
  input  logic                  coll_tick,
  input  logic                  fifth_tick,
  input  logic [4:0]            fifth_num,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic                  vram_ack,
  input  logic [7:0]            vram_rdata,
  output logic                  ovr
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_RD = 2'd1,
    REQ_WR = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          regs [NUM_REGS];
  logic [7:0]          latch;
  logic                phase;
  logic [ADDR_W-1:0]   ptr;
  logic                st_f, st_5s, st_c;
  logic [4:0]          st_num;

  logic                wr1_ph1, cmd_reg, cmd_rdset, cmd_wrset, idx_ok;
  logic                busy, issue_rd, issue_wr, drop;
  logic [ADDR_W-1:0]   ld_ptr, rd_addr;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs[i];
  end

  assign status   = {st_f, st_5s, st_c, st_num};
  assign vram_req = (state != IDLE);
  assign vram_we  = (state == REQ_WR);

  always_comb begin
    wr1_ph1   = wr1_tick & phase;
    cmd_reg   = wr1_ph1 & din[7];
    cmd_rdset = wr1_ph1 & (din[7:6] == 2'b00);
    cmd_wrset = wr1_ph1 & (din[7:6] == 2'b01);
    idx_ok    = ((din[5:0] >> IDX_W) == 6'd0);
    ld_ptr    = {din[ADDR_W-9:0], latch};
    rd_addr   = cmd_rdset ? ld_ptr : ptr;
    busy      = (state != IDLE);
    issue_rd  = (rd0_tick | cmd_rdset) & ~busy;
    issue_wr  = wr0_tick & ~busy;
    drop      = (rd0_tick | cmd_rdset | wr0_tick) & busy;

    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue_rd)      state_nxt = REQ_RD;
        else if (issue_wr) state_nxt = REQ_WR;
      end
      REQ_RD, REQ_WR: if (vram_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      latch      <= '0;
      phase      <= 1'b0;
      ptr        <= '0;
      rdata      <= '0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      ovr        <= 1'b0;
      st_f       <= 1'b0;
      st_5s      <= 1'b0;
      st_c       <= 1'b0;
      st_num     <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr1_tick && !phase) begin
        latch <= din;
        phase <= 1'b1;
      end
      if (wr1_ph1 || rd1_tick || wr0_tick || rd0_tick) phase <= 1'b0;

      if (cmd_reg && idx_ok) regs[din[IDX_W-1:0]] <= latch;
      if (cmd_wrset) ptr <= ld_ptr;

      // A dropped read-setup leaves ptr untouched, like a dropped port-0 access.
      if (issue_rd) begin
        vram_addr <= rd_addr;
        ptr       <= rd_addr + ADDR_W'(1);
      end
      if (issue_wr) begin
        vram_addr  <= ptr;
        vram_wdata <= din;
        rdata      <= din;
        ptr        <= ptr + ADDR_W'(1);
      end
      if (state == REQ_RD && vram_ack) rdata <= vram_rdata;

      ovr <= drop;

      // Sets are applied after the rd1 clear so a coincident event survives.
      if (rd1_tick) begin
        st_f  <= 1'b0;
        st_5s <= 1'b0;
        st_c  <= 1'b0;
      end
      if (frame_tick) st_f <= 1'b1;
      if (coll_tick)  st_c <= 1'b1;
      if (fifth_tick && !st_5s) begin
        st_5s  <= 1'b1;
        st_num <= fifth_num;
      end

      irq <= st_f & regs[1][5];
    end
  end

endmodule

// File: tb/tb_vdp_ctrl_port.sv
// Directed bench for vdp_ctrl_port: VRAM requests are predicted into a queue
// when stimulus is driven and checked when the DUT raises vram_req.
module tb_vdp_ctrl_port;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 14;

  localparam int unsigned S_WR0 = 1, S_RD0 = 2, S_WR1 = 4, S_RD1 = 8,
                          S_FRM = 16, S_COL = 32, S_FIF = 64;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  wr0_tick, rd0_tick, wr1_tick, rd1_tick;
  logic [7:0]            din;
  logic [8*NUM_REGS-1:0] regs_flat;
  logic [7:0]            rdata, status;
  logic                  irq;
  logic                  frame_tick, coll_tick, fifth_tick;
  logic [4:0]            fifth_num;
  logic                  vram_req, vram_we;
  logic [ADDR_W-1:0]     vram_addr;
  logic [7:0]            vram_wdata;
  logic                  vram_ack;
  logic [7:0]            vram_rdata;
  logic                  ovr;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } req_t;

  req_t                  sb[$];
  logic [8*NUM_REGS-1:0] exp_regs;
  int unsigned           checks = 0;
  int unsigned           errors = 0;

  vdp_ctrl_port #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr0_tick(wr0_tick), .rd0_tick(rd0_tick), .wr1_tick(wr1_tick), .rd1_tick(rd1_tick),
    .din(din), .regs_flat(regs_flat), .rdata(rdata), .status(status), .irq(irq),
    .frame_tick(frame_tick), .coll_tick(coll_tick), .fifth_tick(fifth_tick),
    .fifth_num(fifth_num), .vram_req(vram_req), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
    .vram_rdata(vram_rdata), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the selected strobes for exactly one rising edge; return at the next negedge.
  task automatic pulse(input int unsigned sel, input logic [7:0] d);
    @(negedge clk);
    wr0_tick   = (sel & S_WR0) != 0;
    rd0_tick   = (sel & S_RD0) != 0;
    wr1_tick   = (sel & S_WR1) != 0;
    rd1_tick   = (sel & S_RD1) != 0;
    frame_tick = (sel & S_FRM) != 0;
    coll_tick  = (sel & S_COL) != 0;
    fifth_tick = (sel & S_FIF) != 0;
    din        = d;
    fifth_num  = d[4:0];
    @(negedge clk);
    {wr0_tick, rd0_tick, wr1_tick, rd1_tick, frame_tick, coll_tick, fifth_tick} = '0;
  endtask

  task automatic push(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    req_t r;
    r.we = we; r.addr = a; r.data = d;
    sb.push_back(r);
  endtask

  // Wait for a request, compare it with the oldest prediction, then ack after lat cycles.
  task automatic service(input string tag, input int unsigned lat, input logic [7:0] rd);
    req_t        r;
    int unsigned n = 0;
    while (vram_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (vram_req !== 1'b1) begin
      chk({tag, "_req_timeout"}, 64'(vram_req), 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_req"}, 64'(sb.size()), 64'd1);
      return;
    end
    r = sb.pop_front();
    chk({tag, "_we"}, 64'(vram_we), 64'(r.we));
    chk({tag, "_addr"}, 64'(vram_addr), 64'(r.addr));
    if (r.we) chk({tag, "_wdata"}, 64'(vram_wdata), 64'(r.data));
    repeat (lat - 1) @(negedge clk);
    chk({tag, "_addr_stable"}, 64'(vram_addr), 64'(r.addr));
    vram_ack   = 1'b1;
    vram_rdata = rd;
    @(negedge clk);
    vram_ack   = 1'b0;
    vram_rdata = 8'h00;
    chk({tag, "_req_drop"}, 64'(vram_req), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    {wr0_tick, rd0_tick, wr1_tick, rd1_tick, frame_tick, coll_tick, fifth_tick} = '0;
    din = '0; fifth_num = '0; vram_ack = 1'b0; vram_rdata = '0;
    exp_regs = '0;
    repeat (3) @(negedge clk);
    chk("rst_regs", 64'(regs_flat), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_req", 64'(vram_req), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Register write, then an out-of-range index that must be ignored.
    pulse(S_WR1, 8'h5A);
    pulse(S_WR1, 8'h83);
    exp_regs[8*3 +: 8] = 8'h5A;
    chk("reg3_write", 64'(regs_flat), 64'(exp_regs));
    chk("reg_no_req", 64'(vram_req), 64'd0);
    pulse(S_WR1, 8'h11);
    pulse(S_WR1, 8'h88);
    chk("reg_bad_idx", 64'(regs_flat), 64'(exp_regs));

    // Write setup to 0x3F00 and a two-byte burst.
    pulse(S_WR1, 8'h00);
    pulse(S_WR1, 8'h7F);
    chk("wrset_no_req", 64'(vram_req), 64'd0);
    pulse(S_WR0, 8'hAA);
    push(1'b1, 14'h3F00, 8'hAA);
    service("wr_a", 3, 8'h00);
    pulse(S_WR0, 8'hBB);
    push(1'b1, 14'h3F01, 8'hBB);
    service("wr_b", 3, 8'h00);
    chk("wr_rdata", 64'(rdata), 64'hBB);

    // Pointer wrap at the top of VRAM.
    pulse(S_WR1, 8'hFF);
    pulse(S_WR1, 8'h7F);
    pulse(S_WR0, 8'h11);
    push(1'b1, 14'h3FFF, 8'h11);
    service("wrap_a", 2, 8'h00);
    pulse(S_WR0, 8'h22);
    push(1'b1, 14'h0000, 8'h22);
    service("wrap_b", 2, 8'h00);

    // Read setup with prefetch, read-ahead, and a dropped read while busy.
    pulse(S_WR1, 8'h34);
    pulse(S_WR1, 8'h12);
    push(1'b0, 14'h1234, 8'h00);
    service("rdset", 3, 8'hC3);
    chk("rd_prefetch", 64'(rdata), 64'hC3);
    pulse(S_RD0, 8'h00);
    push(1'b0, 14'h1235, 8'h00);
    chk("rd0_req", 64'(vram_req), 64'd1);
    pulse(S_RD0, 8'h00);
    chk("ovr_pulse", 64'(ovr), 64'd1);
    @(negedge clk);
    chk("ovr_clear", 64'(ovr), 64'd0);
    chk("rd_pending_rdata", 64'(rdata), 64'hC3);
    service("rd_next", 2, 8'h5E);
    chk("rd_next_rdata", 64'(rdata), 64'h5E);
    pulse(S_RD0, 8'h00);
    push(1'b0, 14'h1236, 8'h00);
    service("rd_after_drop", 1, 8'h77);

    // Phase reset by rd1: 0x81 becomes a new first byte.
    pulse(S_WR1, 8'h10);
    pulse(S_RD1, 8'h00);
    pulse(S_WR1, 8'h81);
    chk("phase_no_write", 64'(regs_flat), 64'(exp_regs));
    pulse(S_WR1, 8'h82);
    exp_regs[8*2 +: 8] = 8'h81;
    chk("phase_latch", 64'(regs_flat), 64'(exp_regs));

    // Status flags and irq.
    pulse(S_WR1, 8'h20);
    pulse(S_WR1, 8'h81);
    exp_regs[8*1 +: 8] = 8'h20;
    chk("reg1_ie", 64'(regs_flat), 64'(exp_regs));
    pulse(S_FRM, 8'h00);
    chk("f_set", 64'(status), 64'h80);
    chk("irq_lag", 64'(irq), 64'd0);
    @(negedge clk);
    chk("irq_rise", 64'(irq), 64'd1);
    pulse(S_RD1 | S_FRM, 8'h00);
    chk("set_wins", 64'(status), 64'h80);
    pulse(S_RD1, 8'h00);
    chk("f_clear", 64'(status), 64'h00);
    @(negedge clk);
    chk("irq_fall", 64'(irq), 64'd0);
    pulse(S_FIF, 8'h07);
    chk("fifth_first", 64'(status), 64'h47);
    pulse(S_FIF, 8'h09);
    chk("fifth_hold", 64'(status), 64'h47);
    pulse(S_COL, 8'h00);
    chk("coll_set", 64'(status), 64'h67);
    pulse(S_FRM, 8'h00);
    pulse(S_WR1, 8'h00);
    pulse(S_WR1, 8'h81);
    exp_regs[8*1 +: 8] = 8'h00;
    @(negedge clk);
    chk("irq_masked", 64'(irq), 64'd0);
    chk("f_kept", 64'(status), 64'hE7);
    chk("final_regs", 64'(regs_flat), 64'(exp_regs));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
